// File: rtl/rv_pipe_pkg.sv
// Shared RISC-V pipeline types and constants: datapath width, NOP encoding, IF/ID bundle.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv_pipe_pkg;

    localparam int              XLEN         = 32;
    localparam logic [31:0]     NOP_INSTR    = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Sequential next PC; wraps modulo 2^XLEN with no overflow indication
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched bundle, holds it, or replaces it with a NOP bubble.
// Latency: one cycle from dat_i to dat_o when loaded.
// Backpressure: bubble_i wins over load_i; with neither asserted the contents are held (stall).
module if_id_reg (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bubble_i,
    input  logic                load_i,
    input  rv_pipe_pkg::if_id_t dat_i,
    output rv_pipe_pkg::if_id_t dat_o
);
    import rv_pipe_pkg::*;

    if_id_t ifid_q;
    if_id_t ifid_d;

    // Next contents: a bubble keeps pc/pc4 so downstream sees stable link values
    always_comb begin
        ifid_d = ifid_q;
        if (bubble_i) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (load_i) begin
            ifid_d = dat_i;
        end
    end

    // Register with asynchronous reset to an empty (bubble) slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.pc    <= '0;
            ifid_q.pc4   <= XLEN'(4);
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign dat_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, addresses imem, captures word+PC into IF/ID. Optional: IF_MISALIGN_CHECK_EN.
// Latency: instruction at imem_addr_o appears on if_id_* one cycle later (async-read memory).
// Backpressure: start > redirect_i > stall_i > flush_i; stall holds PC and IF/ID, flush bubbles IF/ID.
module if_fetch_stage #(
    parameter int                                 XLEN     = rv_pipe_pkg::XLEN,
    parameter logic [rv_pipe_pkg::XLEN-1:0]       RESET_PC = rv_pipe_pkg::RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
`ifdef IF_MISALIGN_CHECK_EN
    output logic            if_id_misalign_o,
`endif
    output logic            if_id_valid_o
);
    import rv_pipe_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;
    logic            ifid_bubble;
    logic            ifid_load;
    if_id_t          fetch_dat;
    if_id_t          ifid_dat;

    assign pc_plus4         = pc_inc(pc_q);
    // Masking (rather than slicing) keeps all target bits in use; low bits are dropped
    assign redirect_aligned = redirect_pc_i & ~XLEN'(3);

    // Next PC selection in priority order
    always_comb begin
        pc_d = pc_plus4;
        if (start) begin
            pc_d = RESET_PC;
        end else if (redirect_i) begin
            pc_d = redirect_aligned;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID control: redirect beats stall because the redirecting branch is older
    always_comb begin
        ifid_bubble = start | redirect_i | (flush_i & ~stall_i);
        ifid_load   = ~start & ~redirect_i & ~stall_i & ~flush_i;
    end

    assign fetch_dat.pc    = pc_q;
    assign fetch_dat.pc4   = pc_plus4;
    assign fetch_dat.instr = imem_rdata_i;
    assign fetch_dat.valid = 1'b1;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (ifid_bubble),
        .load_i   (ifid_load),
        .dat_i    (fetch_dat),
        .dat_o    (ifid_dat)
    );

    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = ifid_dat.pc;
    assign if_id_pc4_o   = ifid_dat.pc4;
    assign if_id_instr_o = ifid_dat.instr;
    assign if_id_valid_o = ifid_dat.valid;

`ifdef IF_MISALIGN_CHECK_EN
    // pend: last redirect target was misaligned and nothing at the new PC is captured yet
    logic misal_pend_q;
    logic misal_pend_d;
    logic misal_flag_q;
    logic misal_flag_d;

    // Misalign tracking follows the same priority as the IF/ID register
    always_comb begin
        misal_pend_d = misal_pend_q;
        misal_flag_d = misal_flag_q;
        if (start) begin
            misal_pend_d = 1'b0;
            misal_flag_d = 1'b0;
        end else if (redirect_i) begin
            misal_pend_d = |redirect_pc_i[1:0];
            misal_flag_d = 1'b0;
        end else if (stall_i) begin
            misal_pend_d = misal_pend_q;
        end else if (flush_i) begin
            // first word at the new PC is discarded, so its flag goes with it
            misal_pend_d = 1'b0;
            misal_flag_d = 1'b0;
        end else begin
            misal_flag_d = misal_pend_q;
            misal_pend_d = 1'b0;
        end
    end

    // Misalign state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misal_pend_q <= 1'b0;
            misal_flag_q <= 1'b0;
        end else begin
            misal_pend_q <= misal_pend_d;
            misal_flag_q <= misal_flag_d;
        end
    end

    assign if_id_misalign_o = misal_flag_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
`ifdef IF_MISALIGN_CHECK_EN
    logic        if_id_misalign_o;
`endif

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
`ifdef IF_MISALIGN_CHECK_EN
        .if_id_misalign_o (if_id_misalign_o),
`endif
        .if_id_valid_o (if_id_valid_o)
    );

    // Instruction memory: each word is tagged with the word address it lives at
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural view of PC and the instruction slot
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_mis, m_pend;

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_instr = 32'h13;
        m_valid = 1'b0; m_mis = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_edge();
        if (start) begin
            m_instr = 32'h13; m_valid = 0; m_mis = 0; m_pend = 0;
            m_pc = 32'h0;
        end else if (redirect_i) begin
            m_instr = 32'h13; m_valid = 0; m_mis = 0;
            m_pend = (redirect_pc_i % 4) != 0;
            m_pc = redirect_pc_i - (redirect_pc_i % 4);
        end else if (stall_i) begin
            // nothing moves
        end else if (flush_i) begin
            m_instr = 32'h13; m_valid = 0; m_mis = 0; m_pend = 0;
            m_pc = m_pc + 4;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem_word(m_pc);
            m_valid = 1; m_mis = m_pend; m_pend = 0;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".addr"},  imem_addr_o,   m_pc);
        check_eq({tag, ".pc"},    if_id_pc_o,    m_ipc);
        check_eq({tag, ".pc4"},   if_id_pc4_o,   m_ipc4);
        check_eq({tag, ".instr"}, if_id_instr_o, m_instr);
        check_eq({tag, ".valid"}, 32'(if_id_valid_o), 32'(m_valid));
`ifdef IF_MISALIGN_CHECK_EN
        check_eq({tag, ".mis"},   32'(if_id_misalign_o), 32'(m_mis));
`endif
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt,
                         input logic sl, input logic fl);
        start = st; redirect_i = rd; redirect_pc_i = tgt; stall_i = sl; flush_i = fl;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_pulse");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // 1: sequential fetch from 0
        step("seq0"); check_eq("seq0.pc_const", if_id_pc_o, 32'h0);
        step("seq1"); check_eq("seq1.pc_const", if_id_pc_o, 32'h4);
        step("seq2"); check_eq("seq2.pc_const", if_id_pc_o, 32'h8);
        step("seq3");

        // 2: stall at PC 0x10
        check_eq("stall.pre_addr", imem_addr_o, 32'h10);
        drive(0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check_eq("stall.addr_const", imem_addr_o, 32'h10);
            check_eq("stall.pc_const", if_id_pc_o, 32'hC);
        end

        // 3: redirect beats stall
        drive(0, 1, 32'h40, 1, 0);
        step("redir");
        check_eq("redir.instr_const", if_id_instr_o, 32'h13);
        check_eq("redir.addr_const", imem_addr_o, 32'h40);
        drive(0, 0, 32'h0, 0, 0);
        step("redir_next");
        check_eq("redir_next.pc_const", if_id_pc_o, 32'h40);

        // 4: flush at PC 0x20
        drive(0, 1, 32'h20, 0, 0); step("to20");
        drive(0, 0, 32'h0, 0, 1); step("flush");
        check_eq("flush.valid_const", 32'(if_id_valid_o), 32'h0);
        drive(0, 0, 32'h0, 0, 0); step("after_flush");
        check_eq("after_flush.pc_const", if_id_pc_o, 32'h24);

        // 5: start mid-run at PC 0x80
        drive(0, 1, 32'h80, 0, 0); step("to80");
        drive(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("start");
            check_eq("start.addr_const", imem_addr_o, 32'h0);
        end
        drive(0, 0, 32'h0, 0, 0); step("start_fall");
        check_eq("start_fall.pc_const", if_id_pc_o, 32'h0);
        step("run"); step("run");
        rst_pulse();
        step("post_rst");

        // 6: PC wrap and misaligned redirect
        drive(0, 1, 32'hFFFF_FFFC, 0, 0); step("to_top");
        drive(0, 0, 32'h0, 0, 0); step("wrap");
        check_eq("wrap.addr_const", imem_addr_o, 32'h0);
        check_eq("wrap.pc4_const", if_id_pc4_o, 32'h0);
        drive(0, 1, 32'h42, 0, 0); step("misal");
        check_eq("misal.addr_const", imem_addr_o, 32'h40);
        drive(0, 0, 32'h0, 0, 0); step("misal_cap");
        step("misal_clr");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] tgt;
            tgt = $urandom();
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            step("rand");
            if (n % 300 == 150) rst_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
